edge_window_ctrl: RTL and testbench

- Sequencing controller for the Sobel edge-detection datapath.
- Tracks incoming video timing (VSYNC/DE) one pixel strobe at a time and generates line-buffer write/read bank selects and addresses.
- Produces a 3x3-window-valid qualifier with window-centre coordinates.
- Measures frame geometry and flags malformed lines. Sits between the input sync/pixel capture stage and the line buffers and kernel pipeline.

---
 rtl/edge_window_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_edge_window_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_window_ctrl.sv
// Sobel window sequencer: follows VSYNC/DE on pixel strobes and drives line-buffer banks and
// addresses, the 3x3 window qualifier, frame geometry and line-length error reporting.
module edge_window_ctrl #(
   parameter int unsigned MAX_WIDTH  = 1024,
   parameter int unsigned MAX_HEIGHT = 768,
   parameter int unsigned COL_W      = 11,
   parameter int unsigned ROW_W      = 10
) (
   input  logic             I_CORE_CLK,
   input  logic             I_RST_N,
   input  logic             I_EN,
   input  logic             I_PIX_STB,
   input  logic             I_VSYNC,
   input  logic             I_DE,
   output logic             O_LB_WE,
   output logic [1:0]       O_LB_WR_SEL,
   output logic [1:0]       O_LB_RD_SEL_TOP,
   output logic [1:0]       O_LB_RD_SEL_MID,
   output logic [COL_W-1:0] O_LB_ADDR,
   output logic             O_WIN_VALID,
   output logic [COL_W-1:0] O_WIN_COL,
   output logic [ROW_W-1:0] O_WIN_ROW,
   output logic             O_LINE_DONE,
   output logic             O_FRAME_DONE,
   output logic [COL_W-1:0] O_WIDTH,
   output logic [ROW_W-1:0] O_HEIGHT,
   output logic             O_ERR_WIDTH,
   output logic [1:0]       O_STATE
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StVblank = 2'd1,
      StLine   = 2'd2,
      StHblank = 2'd3
   } state_t;

   localparam logic [COL_W-1:0] ColMax = COL_W'(MAX_WIDTH);
   localparam logic [ROW_W-1:0] RowMax = ROW_W'(MAX_HEIGHT);

   state_t           state, state_next;
   logic             vs_prev, vs_prev_next, de_prev, de_prev_next;
   logic [COL_W-1:0] col, col_next;
   logic [ROW_W-1:0] row, row_next;
   logic [1:0]       wr_sel, wr_sel_next;
   logic             first_line, first_line_next;
   logic [COL_W-1:0] width, width_next;
   logic [ROW_W-1:0] height, height_next;
   logic             err, err_next;
   logic             lb_we, lb_we_next;
   logic [1:0]       lb_wr_sel, lb_wr_sel_next;
   logic [1:0]       rd_top, rd_top_next, rd_mid, rd_mid_next;
   logic [COL_W-1:0] lb_addr, lb_addr_next;
   logic             win_valid, win_valid_next;
   logic [COL_W-1:0] win_col, win_col_next;
   logic [ROW_W-1:0] win_row, win_row_next;
   logic             line_done, line_done_next;
   logic             frame_done, frame_done_next;

   logic vs_rise, de_rise, de_fall;
   logic do_pixel, do_line_end, do_frame_start, fs_pulse, partial;

   assign vs_rise = I_VSYNC & ~vs_prev;
   assign de_rise = I_DE & ~de_prev;
   assign de_fall = ~I_DE & de_prev;

   function automatic logic [1:0] inc3(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Event decode: which actions this strobe triggers.
   always_comb begin
      state_next     = state;
      do_pixel       = 1'b0;
      do_line_end    = 1'b0;
      do_frame_start = 1'b0;
      fs_pulse       = 1'b0;
      partial        = 1'b0;
      if (I_EN && I_PIX_STB) begin
         unique case (state)
            StIdle: begin
               if (vs_rise) begin
                  do_frame_start = 1'b1;
                  state_next     = StVblank;
               end
            end
            StVblank, StHblank: begin
               if (vs_rise) begin
                  do_frame_start = 1'b1;
                  fs_pulse       = 1'b1;
                  state_next     = StVblank;
               end else if (de_rise) begin
                  do_pixel   = 1'b1;
                  state_next = StLine;
               end
            end
            StLine: begin
               if (de_fall) begin
                  do_line_end = 1'b1;
                  state_next  = StHblank;
                  if (vs_rise) begin
                     do_frame_start = 1'b1;
                     fs_pulse       = 1'b1;
                     state_next     = StVblank;
                  end
               end else if (vs_rise) begin
                  // Frame restarted mid-line: the truncated line is reported in the new frame.
                  do_frame_start = 1'b1;
                  fs_pulse       = 1'b1;
                  partial        = 1'b1;
                  state_next     = StVblank;
               end else if (I_DE) begin
                  do_pixel = 1'b1;
               end
            end
            default: state_next = StIdle;
         endcase
      end
      if (!I_EN) begin
         state_next = StIdle;
      end
   end

   // Datapath updates, applied in order: pixel, line end, then frame start.
   always_comb begin
      vs_prev_next    = vs_prev;
      de_prev_next    = de_prev;
      col_next        = col;
      row_next        = row;
      wr_sel_next     = wr_sel;
      first_line_next = first_line;
      width_next      = width;
      height_next     = height;
      err_next        = err;
      lb_we_next      = 1'b0;
      lb_wr_sel_next  = lb_wr_sel;
      rd_top_next     = rd_top;
      rd_mid_next     = rd_mid;
      lb_addr_next    = lb_addr;
      win_valid_next  = 1'b0;
      win_col_next    = win_col;
      win_row_next    = win_row;
      line_done_next  = 1'b0;
      frame_done_next = 1'b0;

      if (I_PIX_STB) begin
         vs_prev_next = I_VSYNC;
         de_prev_next = I_DE;
      end

      if (!I_EN) begin
         col_next    = '0;
         row_next    = '0;
         wr_sel_next = 2'd0;
      end else begin
         if (do_pixel) begin
            if (col < ColMax) begin
               lb_we_next     = 1'b1;
               lb_addr_next   = col;
               lb_wr_sel_next = wr_sel;
               if (row >= ROW_W'(2) && col >= COL_W'(2)) begin
                  win_valid_next = 1'b1;
                  win_col_next   = col - COL_W'(1);
                  win_row_next   = row - ROW_W'(1);
               end
               col_next = col + COL_W'(1);
            end else begin
               err_next = 1'b1;
            end
         end
         if (do_line_end) begin
            line_done_next = 1'b1;
            if (first_line) begin
               width_next      = col;
               first_line_next = 1'b0;
            end else if (col != width) begin
               err_next = 1'b1;
            end
            wr_sel_next = inc3(wr_sel);
            if (row < RowMax) begin
               row_next = row + ROW_W'(1);
            end else begin
               err_next = 1'b1;
            end
            col_next = '0;
         end
         if (do_frame_start) begin
            if (fs_pulse && row_next != '0) begin
               frame_done_next = 1'b1;
               height_next     = row_next;
            end
            row_next        = '0;
            col_next        = '0;
            wr_sel_next     = 2'd0;
            err_next        = partial;
            first_line_next = 1'b1;
         end
      end

      if (!I_EN || do_line_end || do_frame_start) begin
         rd_top_next = inc3(wr_sel_next);
         rd_mid_next = inc3(inc3(wr_sel_next));
      end
   end

   always_ff @(posedge I_CORE_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state      <= StIdle;
         vs_prev    <= 1'b0;
         de_prev    <= 1'b0;
         col        <= '0;
         row        <= '0;
         wr_sel     <= 2'd0;
         first_line <= 1'b0;
         width      <= '0;
         height     <= '0;
         err        <= 1'b0;
         lb_we      <= 1'b0;
         lb_wr_sel  <= 2'd0;
         rd_top     <= 2'd0;
         rd_mid     <= 2'd0;
         lb_addr    <= '0;
         win_valid  <= 1'b0;
         win_col    <= '0;
         win_row    <= '0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         vs_prev    <= vs_prev_next;
         de_prev    <= de_prev_next;
         col        <= col_next;
         row        <= row_next;
         wr_sel     <= wr_sel_next;
         first_line <= first_line_next;
         width      <= width_next;
         height     <= height_next;
         err        <= err_next;
         lb_we      <= lb_we_next;
         lb_wr_sel  <= lb_wr_sel_next;
         rd_top     <= rd_top_next;
         rd_mid     <= rd_mid_next;
         lb_addr    <= lb_addr_next;
         win_valid  <= win_valid_next;
         win_col    <= win_col_next;
         win_row    <= win_row_next;
         line_done  <= line_done_next;
         frame_done <= frame_done_next;
      end
   end

   assign O_LB_WE         = lb_we;
   assign O_LB_WR_SEL     = lb_wr_sel;
   assign O_LB_RD_SEL_TOP = rd_top;
   assign O_LB_RD_SEL_MID = rd_mid;
   assign O_LB_ADDR       = lb_addr;
   assign O_WIN_VALID     = win_valid;
   assign O_WIN_COL       = win_col;
   assign O_WIN_ROW       = win_row;
   assign O_LINE_DONE     = line_done;
   assign O_FRAME_DONE    = frame_done;
   assign O_WIDTH         = width;
   assign O_HEIGHT        = height;
   assign O_ERR_WIDTH     = err;
   assign O_STATE         = state;

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Bench for edge_window_ctrl: directed and random video timing, a frame-level reference model
// feeding a scoreboard queue, and a monitor that checks every output event against it.
module tb_edge_window_ctrl;
   localparam int MAXW = 16;
   localparam int MAXH = 12;
   localparam int CW   = 5;
   localparam int RW   = 4;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, stb = 1'b0, vs = 1'b0, de = 1'b0;
   logic          lb_we, win_valid, line_done, frame_done, err_width;
   logic [1:0]    wr_sel, rd_top, rd_mid, state;
   logic [CW-1:0] lb_addr, win_col, width;
   logic [RW-1:0] win_row, height;

   always #5 clk = ~clk;

   edge_window_ctrl #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH), .COL_W(CW), .ROW_W(RW)) dut (
      .I_CORE_CLK(clk), .I_RST_N(rst_n), .I_EN(en), .I_PIX_STB(stb), .I_VSYNC(vs), .I_DE(de),
      .O_LB_WE(lb_we), .O_LB_WR_SEL(wr_sel), .O_LB_RD_SEL_TOP(rd_top),
      .O_LB_RD_SEL_MID(rd_mid), .O_LB_ADDR(lb_addr), .O_WIN_VALID(win_valid),
      .O_WIN_COL(win_col), .O_WIN_ROW(win_row), .O_LINE_DONE(line_done),
      .O_FRAME_DONE(frame_done), .O_WIDTH(width), .O_HEIGHT(height), .O_ERR_WIDTH(err_width),
      .O_STATE(state)
   );

   typedef struct {
      bit we; int addr; int wsel; int top; int mid; bit wv; int wc; int wrow;
      bit ld; bit fd; int width; int height; bit err; int st;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0, errors = 0;
   int   n_we = 0, n_wv = 0, n_fd = 0, max_addr = 0;
   bit   both_seen = 0;
   bit   cur_en = 1'b0;

   // Reference model: mode 0 idle, 1 vertical blank, 2 in line, 3 horizontal blank.
   int m_mode, m_col, m_row, m_wr, m_width, m_height;
   bit m_err, m_first, m_vp, m_dp;

   task automatic model_reset();
      m_mode = 0; m_col = 0; m_row = 0; m_wr = 0; m_width = 0; m_height = 0;
      m_err = 0; m_first = 0; m_vp = 0; m_dp = 0;
   endtask

   task automatic model_cycle(input bit e, input bit s, input bit v, input bit d);
      bit   vr, dr, df, fs, pulse, le, px, part;
      exp_t x;
      x = '{default: 0};
      if (!e) begin
         m_mode = 0; m_col = 0; m_row = 0; m_wr = 0;
         if (s) begin m_vp = v; m_dp = d; end
         return;
      end
      if (!s) return;
      vr = v && !m_vp; dr = d && !m_dp; df = !d && m_dp;
      m_vp = v; m_dp = d;
      fs = 0; pulse = 0; le = 0; px = 0; part = 0;
      if (m_mode == 0) begin
         if (vr) begin fs = 1; m_mode = 1; end
      end else if (m_mode == 2) begin
         if (df) le = 1;
         if (vr) begin fs = 1; pulse = 1; part = !df; m_mode = 1; end
         else if (df) m_mode = 3;
         else if (d) px = 1;
      end else begin
         if (vr) begin fs = 1; pulse = 1; m_mode = 1; end
         else if (dr) begin px = 1; m_mode = 2; end
      end
      if (px) begin
         if (m_col < MAXW) begin
            x.we = 1; x.addr = m_col; x.wsel = m_wr;
            if (m_row >= 2 && m_col >= 2) begin x.wv = 1; x.wc = m_col - 1; x.wrow = m_row - 1; end
            m_col++;
         end else m_err = 1;
      end
      if (le) begin
         x.ld = 1;
         if (m_first) begin m_width = m_col; m_first = 0; end
         else if (m_col != m_width) m_err = 1;
         m_wr = (m_wr + 1) % 3;
         if (m_row < MAXH) m_row++; else m_err = 1;
         m_col = 0;
      end
      if (fs) begin
         if (pulse && m_row > 0) begin x.fd = 1; m_height = m_row; end
         m_row = 0; m_col = 0; m_wr = 0; m_err = part; m_first = 1;
      end
      x.width = m_width; x.height = m_height; x.err = m_err; x.st = m_mode;
      x.top = (m_wr + 1) % 3; x.mid = (m_wr + 2) % 3;
      if (x.we || x.ld || x.fd) sb.push_back(x);
   endtask

   function automatic bit rec_ok(input exp_t x);
      if (lb_we != x.we || win_valid != x.wv || line_done != x.ld || frame_done != x.fd) return 0;
      if (err_width != x.err || int'(width) != x.width || int'(height) != x.height) return 0;
      if (int'(state) != x.st || int'(rd_top) != x.top || int'(rd_mid) != x.mid) return 0;
      if (x.we && (int'(lb_addr) != x.addr || int'(wr_sel) != x.wsel)) return 0;
      if (x.wv && (int'(win_col) != x.wc || int'(win_row) != x.wrow)) return 0;
      return 1;
   endfunction

   always @(negedge clk) begin
      if (rst_n && (lb_we || win_valid || line_done || frame_done)) begin
         if (lb_we) begin
            n_we++;
            if (int'(lb_addr) > max_addr) max_addr = int'(lb_addr);
         end
         if (win_valid) n_wv++;
         if (frame_done) n_fd++;
         if (line_done && frame_done) both_seen = 1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_output: got we=%0d wv=%0d ld=%0d fd=%0d, required no event",
                     lb_we, win_valid, line_done, frame_done);
         end else begin
            mon_e = sb.pop_front();
            if (!rec_ok(mon_e)) begin
               errors++;
               $display("FAIL event_record: got we=%0d addr=%0d wsel=%0d top=%0d mid=%0d wv=%0d c=%0d r=%0d ld=%0d fd=%0d w=%0d h=%0d err=%0d st=%0d; required we=%0d addr=%0d wsel=%0d top=%0d mid=%0d wv=%0d c=%0d r=%0d ld=%0d fd=%0d w=%0d h=%0d err=%0d st=%0d",
                  lb_we, lb_addr, wr_sel, rd_top, rd_mid, win_valid, win_col, win_row,
                  line_done, frame_done, width, height, err_width, state,
                  mon_e.we, mon_e.addr, mon_e.wsel, mon_e.top, mon_e.mid, mon_e.wv, mon_e.wc,
                  mon_e.wrow, mon_e.ld, mon_e.fd, mon_e.width, mon_e.height, mon_e.err, mon_e.st);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic cyc(input bit s, input bit v, input bit d);
      @(negedge clk);
      en = cur_en; stb = s; vs = v; de = d;
      model_cycle(cur_en, s, v, d);
   endtask

   task automatic strobe(input bit v, input bit d);
      cyc(1'b1, v, d);
      if ($urandom_range(0, 3) == 0) cyc(1'b0, v, d);
   endtask

   task automatic drain();
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic vsync();
      strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b0);
   endtask

   task automatic line(input int w);
      for (int p = 0; p < w; p++) strobe(1'b0, 1'b1);
      strobe(1'b0, 1'b0);
      strobe(1'b0, 1'b0);
   endtask

   task automatic frame(input int w, input int h, input bit sim, input int drop_line);
      vsync();
      for (int l = 0; l < h; l++) begin
         for (int p = 0; p < w; p++) begin
            if (l == drop_line && p == w / 2) begin
               cur_en = 1'b0;
               cyc(1'b0, 1'b0, 1'b1);
               cyc(1'b0, 1'b0, 1'b1);
               cur_en = 1'b1;
            end
            strobe(1'b0, 1'b1);
         end
         if (sim && l == h - 1) vsync();
         else begin strobe(1'b0, 1'b0); strobe(1'b0, 1'b0); end
      end
   endtask

   int we0, wv0, fd0;

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_outputs", int'(|{lb_we, wr_sel, rd_top, rd_mid, lb_addr, win_valid, win_col,
            win_row, line_done, frame_done, width, height, err_width, state}), 0);
      rst_n = 1'b1;
      cur_en = 1'b1;

      // Reset asserted in the middle of a line.
      vsync();
      repeat (5) strobe(1'b0, 1'b1);
      drain();
      #2 rst_n = 1'b0;
      #1 check("reset_midline_outputs", int'(|{lb_we, wr_sel, rd_top, rd_mid, lb_addr,
               win_valid, win_col, win_row, line_done, frame_done, width, height, err_width,
               state}), 0);
      model_reset();
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      we0 = n_we;
      repeat (3) strobe(1'b0, 1'b1);
      line(4);
      drain();
      check("no_write_before_vsync", n_we - we0, 0);
      check("idle_state", int'(state), 0);

      // 8x4 frame.
      we0 = n_we; wv0 = n_wv; fd0 = n_fd;
      vsync();
      for (int l = 0; l < 4; l++) line(8);
      drain();
      check("frame8x4_writes", n_we - we0, 32);
      check("frame8x4_windows", n_wv - wv0, 12);
      check("frame8x4_width", int'(width), 8);
      vsync();
      drain();
      check("frame8x4_frame_done", n_fd - fd0, 1);
      check("frame8x4_height", int'(height), 4);

      // Width mismatch inside a frame.
      line(8); line(8); line(7);
      drain();
      check("mismatch_err_set", int'(err_width), 1);
      line(8);
      drain();
      check("mismatch_err_sticky", int'(err_width), 1);
      vsync();
      drain();
      check("mismatch_err_cleared", int'(err_width), 0);

      // Line longer than MAX_WIDTH.
      we0 = n_we; max_addr = 0;
      line(20);
      drain();
      check("overflow_writes", n_we - we0, 16);
      check("overflow_max_addr", max_addr, 15);
      check("overflow_err", int'(err_width), 1);

      // de_fall and vs_rise on the same strobe.
      both_seen = 0;
      vsync();
      line(8); line(8);
      repeat (8) strobe(1'b0, 1'b1);
      vsync();
      drain();
      check("sim_pulses_same_cycle", int'(both_seen), 1);
      check("sim_height", int'(height), 3);
      check("sim_rd_top", int'(rd_top), 1);
      check("sim_rd_mid", int'(rd_mid), 2);

      // Enable dropped mid-frame.
      vsync();
      line(8); line(8);
      repeat (3) strobe(1'b0, 1'b1);
      cur_en = 1'b0;
      repeat (3) cyc(1'b0, 1'b0, 1'b1);
      check("en_drop_state", int'(state), 0);
      check("en_drop_width_held", int'(width), 8);
      check("en_drop_height_held", int'(height), 3);
      cur_en = 1'b1;
      we0 = n_we;
      strobe(1'b0, 1'b0);
      line(4);
      drain();
      check("en_restore_no_write", n_we - we0, 0);

      // Randomised frames.
      for (int f = 0; f < 25; f++) begin
         int w, h, drop;
         bit sim;
         w = $urandom_range(1, 18);
         h = $urandom_range(1, 14);
         sim = ($urandom_range(0, 3) == 0);
         drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, h - 1)) : -1;
         frame(w, h, sim, drop);
      end
      vsync();
      drain();
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
